// File: rtl/firip_pkg.sv
// Shared types and default sizing for the coefficient bank loader.
// Holds the loader FSM state enum and default COEFW/TM.
package firip_pkg;
  localparam int COEFW_DEF = 18;
  localparam int TM_DEF    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL,
    S_ARMED
  } loader_state_t;
endpackage

// File: rtl/tm_counter.sv
// Time-multiplex index counter, wraps TM-1 -> 0 on run.
// wrap flags the last index of the multiplex cycle.
module tm_counter #(
  parameter int TM = 2,
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [CW-1:0] count,
  output logic          wrap
);
  localparam logic [CW-1:0] LAST = CW'(TM - 1);

  logic [CW-1:0] r_count;

  assign count = r_count;
  assign wrap  = (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= wrap ? '0 : r_count + CW'(1);
    end
  end
endmodule

// File: rtl/coef_bank_loader.sv
// Double-buffered coefficient bank, swapped on the multiplex wrap.
// COEF_BANK_READBACK_EN adds a registered shadow readback port.
module coef_bank_loader
  import firip_pkg::*;
#(
  parameter int COEFW = COEFW_DEF,
  parameter int TM    = TM_DEF,
  parameter int CW    = (TM > 1) ? $clog2(TM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [COEFW-1:0] load_data,
  input  logic             load_last,
  input  logic             swap_req,
  output logic             swap_done,
  output logic             load_err,
  output logic [CW-1:0]    counter_out,
`ifdef COEF_BANK_READBACK_EN
  input  logic [CW-1:0]    rd_addr,
  output logic [COEFW-1:0] rd_data,
`endif
  output logic [COEFW-1:0] coef_pack [TM]
);
  localparam logic [CW-1:0] LAST = CW'(TM - 1);

  loader_state_t    r_state;
  loader_state_t    w_state_nxt;
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    w_wptr_nxt;
  logic             r_ready;
  logic             r_done;
  logic             r_err;
  logic             w_acc;
  logic             w_err;
  logic             w_swap;
  logic             w_wrap;
  logic [COEFW-1:0] r_shadow [TM];
  logic [COEFW-1:0] r_active [TM];

  tm_counter #(
    .TM (TM),
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .count (counter_out),
    .wrap  (w_wrap)
  );

  assign w_acc      = load_valid && r_ready;
  assign load_ready = r_ready;
  assign swap_done  = r_done;
  assign load_err   = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_wptr_nxt  = r_wptr;
    w_err       = 1'b0;
    w_swap      = 1'b0;
    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (w_acc) begin
          if ((r_wptr == LAST) && load_last) begin
            w_wptr_nxt  = '0;
            w_state_nxt = S_FULL;
          end else if ((r_wptr == LAST) || load_last) begin
            w_err       = 1'b1;
            w_wptr_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_wptr_nxt  = r_wptr + CW'(1);
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_FULL: begin
        if (swap_req) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        // Swap only on the wrap edge so a multiplex cycle never mixes banks
        if (run && w_wrap) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wptr  <= w_wptr_nxt;
      r_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
      r_done  <= w_swap;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TM; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_acc) r_shadow[r_wptr] <= load_data;
      if (w_swap) begin
        for (int i = 0; i < TM; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < TM; i++) coef_pack[i] = r_active[i];
  end

`ifdef COEF_BANK_READBACK_EN
  logic [COEFW-1:0] r_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_shadow[rd_addr];
  end

  assign rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_coef_bank_loader.sv
// Bench for coef_bank_loader, TM=4, against a beat-queue model.
// Directed scenarios followed by randomized traffic.
module tb_coef_bank_loader;
  localparam int COEFW = 18;
  localparam int TM    = 4;
  localparam int CW    = 2;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             load_valid;
  logic             load_ready;
  logic [COEFW-1:0] load_data;
  logic             load_last;
  logic             swap_req;
  logic             swap_done;
  logic             load_err;
  logic [CW-1:0]    counter_out;
  logic [COEFW-1:0] coef_pack [TM];
`ifdef COEF_BANK_READBACK_EN
  logic [CW-1:0]    rd_addr;
  logic [COEFW-1:0] rd_data;
`endif

  coef_bank_loader #(
    .COEFW (COEFW),
    .TM    (TM),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .load_err    (load_err),
    .counter_out (counter_out),
`ifdef COEF_BANK_READBACK_EN
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
`endif
    .coef_pack   (coef_pack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: a set is a queue of accepted beats
  int q[$];
  int m_cnt;
  bit m_full;
  bit m_armed;
  bit m_rdy;
  bit e_err;
  bit e_done;
  int e_rd;
  int m_shadow [TM];
  int m_active [TM];

  task automatic m_reset();
    q.delete();
    m_cnt   = 0;
    m_full  = 0;
    m_armed = 0;
    m_rdy   = 0;
    e_err   = 0;
    e_done  = 0;
    e_rd    = 0;
    for (int i = 0; i < TM; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
  endtask

  task automatic m_edge();
    e_err  = 0;
    e_done = 0;
`ifdef COEF_BANK_READBACK_EN
    e_rd = m_shadow[rd_addr];
`endif
    if (m_rdy && load_valid) begin
      m_shadow[q.size()] = int'(load_data);
      q.push_back(int'(load_data));
      if (load_last && q.size() == TM) begin
        m_full = 1;
        q.delete();
      end else if (load_last || q.size() == TM) begin
        e_err = 1;
        q.delete();
      end
    end else if (m_full && swap_req) begin
      m_full  = 0;
      m_armed = 1;
    end else if (m_armed && run && m_cnt == TM - 1) begin
      for (int i = 0; i < TM; i++) m_active[i] = m_shadow[i];
      m_armed = 0;
      e_done  = 1;
    end
    if (run) m_cnt = (m_cnt + 1) % TM;
    m_rdy = !(m_full || m_armed);
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("counter", 32'(counter_out), 32'(m_cnt));
    chk("ready", 32'(load_ready), 32'(m_rdy));
    chk("swap_done", 32'(swap_done), 32'(e_done));
    chk("load_err", 32'(load_err), 32'(e_err));
    for (int i = 0; i < TM; i++) chk("coef", 32'(coef_pack[i]), 32'(m_active[i]));
`ifdef COEF_BANK_READBACK_EN
    chk("rd_data", 32'(rd_data), 32'(e_rd));
`endif
  endtask

  task automatic beat(input int d, input bit last);
    load_valid = 1;
    load_data  = COEFW'(d);
    load_last  = last;
    step();
    load_valid = 0;
    load_last  = 0;
  endtask

  task automatic wait_swap(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 2 * TM + 2 && !seen; k++) begin
      step();
      if (swap_done) begin
        seen = 1;
        chk({tag, "_cnt0"}, 32'(counter_out), 0);
      end
    end
    chk({tag, "_seen"}, 32'(seen), 1);
  endtask

  task automatic chk_pack(input string tag, input int a, input int b,
                          input int c, input int d);
    chk({tag, "0"}, 32'(coef_pack[0]), 32'(a));
    chk({tag, "1"}, 32'(coef_pack[1]), 32'(b));
    chk({tag, "2"}, 32'(coef_pack[2]), 32'(c));
    chk({tag, "3"}, 32'(coef_pack[3]), 32'(d));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cnt"}, 32'(counter_out), 0);
    chk({tag, "_rdy"}, 32'(load_ready), 0);
    chk({tag, "_done"}, 32'(swap_done), 0);
    chk({tag, "_err"}, 32'(load_err), 0);
    chk_pack({tag, "_pack"}, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n      = 0;
    run        = 0;
    load_valid = 0;
    load_data  = '0;
    load_last  = 0;
    swap_req   = 0;
`ifdef COEF_BANK_READBACK_EN
    rd_addr    = '0;
`endif
    m_reset();
    #3;
    chk_reset_outs("rst0");
    @(posedge clk);
    #1 rst_n = 1;
    chk("rst0_rdy_hold", 32'(load_ready), 0);
    step();
    chk("rst0_rdy_up", 32'(load_ready), 1);

    // nominal load and swap
    run = 1;
    beat(10, 0);
    beat(20, 0);
    beat(30, 0);
    beat(40, 1);
`ifdef COEF_BANK_READBACK_EN
    rd_addr = 2;
    step();
    chk("readback", 32'(rd_data), 30);
`endif
    swap_req = 1;
    step();
    swap_req = 0;
    wait_swap("swap1");
    chk_pack("set1_", 10, 20, 30, 40);

    // early last
    beat(1, 0);
    beat(2, 0);
    beat(3, 1);
    chk("early_err", 32'(load_err), 1);
    step();
    chk("early_err_pulse", 32'(load_err), 0);
    chk("early_rdy", 32'(load_ready), 1);
    chk_pack("early_", 10, 20, 30, 40);

    // missing last
    for (int i = 0; i < TM; i++) beat(50 + i, 0);
    chk("miss_err", 32'(load_err), 1);

    // swap requests outside S_FULL are ignored
    swap_req = 1;
    step();
    load_valid = 1;
    load_data  = 5;
    step();
    load_data  = 6;
    step();
    load_valid = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("ign_done", 32'(swap_done), 0);
    end
    swap_req = 0;
    chk_pack("ign_", 10, 20, 30, 40);

    // run held low while armed
    beat(7, 0);
    beat(8, 1);
    swap_req = 1;
    step();
    swap_req = 0;
    run = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_cnt", 32'(counter_out), 32'(m_cnt));
      chk("hold_done", 32'(swap_done), 0);
    end
    chk_pack("hold_", 10, 20, 30, 40);
    run = 1;
    wait_swap("swap2");
    chk_pack("set2_", 5, 6, 7, 8);

    // reset in the middle of a set
    beat(100, 0);
    beat(200, 0);
    rst_n = 0;
    #2;
    chk_reset_outs("rst1");
    m_reset();
    @(posedge clk);
    #1 rst_n = 1;
    chk("rst1_rdy_hold", 32'(load_ready), 0);
    step();
    chk("rst1_rdy_up", 32'(load_ready), 1);
    beat(11, 0);
    beat(22, 0);
    beat(33, 0);
    beat(44, 1);
    swap_req = 1;
    step();
    swap_req = 0;
    wait_swap("swap3");
    chk_pack("set3_", 11, 22, 33, 44);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = COEFW'($urandom);
      load_last  = ($urandom_range(0, 5) == 0) ||
                   (q.size() == TM - 1 && $urandom_range(0, 3) != 0);
      swap_req   = ($urandom_range(0, 3) == 0);
      run        = ($urandom_range(0, 4) != 0);
`ifdef COEF_BANK_READBACK_EN
      rd_addr    = CW'($urandom);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/coef_bank_loader.md
COEF_BANK_LOADER -- requirements
Module: coef_bank_loader

Interface
REQ-001 SHALL have parameter COEFW, default 18, giving the coefficient word width in bits.
REQ-002 SHALL have parameter TM, default 2, giving the time-multiplex factor (taps per multiplier), legal range 1..256.
REQ-003 SHALL have parameter CW, default 1, giving the counter width, equal to max(1, clog2(TM)).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port run, input, 1 bit: time-multiplex counter advance enable.
REQ-007 SHALL have port load_valid, input, 1 bit: the coefficient beat is valid.
REQ-008 SHALL have port load_ready, output, 1 bit: the loader accepts a beat.
REQ-009 SHALL have port load_data, input, COEFW bits: coefficient word, tap order 0..TM-1.
REQ-010 SHALL have port load_last, input, 1 bit: marks the final beat of a set.
REQ-011 SHALL have port swap_req, input, 1 bit: a single-cycle request to activate the shadow bank.
REQ-012 SHALL have port swap_done, output, 1 bit: single-cycle pulse marking that the active bank was updated.
REQ-013 SHALL have port load_err, output, 1 bit: single-cycle pulse marking a malformed set.
REQ-014 SHALL have port counter_out, output, CW bits: the time-multiplex index fed to the coefficient multiplexer.
REQ-015 SHALL have port coef_pack, output, unpacked array [TM] of COEFW bits: the active coefficient bank.

Function
REQ-016 SHALL hold two banks, shadow and active, each of TM words, and drive coef_pack only from the active bank.
REQ-017 SHALL advance counter_out by 1 on each edge where run=1, wrapping TM-1 -> 0, and hold it when run=0.
REQ-018 SHALL implement states S_IDLE, S_LOAD, S_FULL and S_ARMED, with a write pointer wptr of width CW.
REQ-019 SHALL drive load_ready=1 only in S_IDLE and S_LOAD; a beat is accepted when load_valid=1 and load_ready=1.
REQ-020 SHALL, on an accepted beat, write shadow[wptr] <= load_data and apply the REQ-021 to REQ-023 transitions on the same edge.
REQ-021 SHALL, on an accepted beat with wptr<TM-1 and load_last=0, increment wptr and go to S_LOAD.
REQ-022 SHALL, on an accepted beat with wptr==TM-1 and load_last=1, clear wptr and go to S_FULL.
REQ-023 SHALL, on an accepted beat that is early last (wptr<TM-1) or missing last (wptr==TM-1), pulse load_err for 1 cycle, clear wptr and go to S_IDLE, leaving the active bank untouched.
REQ-024 SHALL, in S_FULL, go to S_ARMED on swap_req=1; swap_req in any other state is ignored with no error.
REQ-025 SHALL, in S_ARMED, on the edge where run=1 and counter_out==TM-1, copy all of shadow into active, go to S_IDLE and assert swap_done for exactly the following cycle (counter_out==0).
REQ-026 SHALL keep coef_pack constant between swap edges, so that no multiplex cycle ever mixes old and new coefficients.
REQ-027 SHALL, with TM=1, treat every run=1 edge as the wrap edge.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force counter_out=0, wptr=0, state=S_IDLE, load_ready=0, swap_done=0, load_err=0, and both banks to all zeros.
REQ-029 SHALL register load_ready, returning it to 1 on the first edge after rst_n deasserts.
REQ-030 SHALL discard a partially loaded or armed set when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, with macro COEF_BANK_READBACK_EN defined, add input rd_addr (CW bits) and output rd_data (COEFW bits), where rd_data = shadow[rd_addr] registered with 1-cycle latency and reset to 0.
REQ-032 SHALL, without COEF_BANK_READBACK_EN, have neither readback port nor readback logic.

Structure
REQ-033 SHALL place the state enum type (loader_state_t) and the default COEFW/TM constants in the shared package firip_pkg.
REQ-034 SHALL implement the counter of REQ-017 as sub-module tm_counter, with ports clk, rst_n, run, count and wrap, where wrap is high when count==TM-1.

Verification
REQ-035 SHALL verify that TM=4 with words 10, 20, 30, 40 (last on 40) followed by swap_req produces swap_done coincident with counter_out=0 and coef_pack={10,20,30,40}.
REQ-036 SHALL verify that TM=4 with 3 beats, the 3rd carrying load_last, produces load_err=1 for 1 cycle, keeps coef_pack unchanged, and returns to S_IDLE.
REQ-037 SHALL verify that swap_req issued in S_IDLE or S_LOAD produces no swap_done and no change to coef_pack.
REQ-038 SHALL verify that holding run=0 for 10 cycles while in S_ARMED freezes counter_out and delays the swap until the first wrap after run=1.
REQ-039 SHALL verify that rst_n pulsed low after 2 of 4 beats gives all-zero outputs, load_ready=0, then load_ready=1 one edge after release, and that a fresh 4-beat set then loads correctly.
REQ-040 SHALL verify, with COEF_BANK_READBACK_EN defined, that after the REQ-035 load, rd_addr=2 returns rd_data=30 one cycle later.
